// File: rtl/dyser_port_buf_if.sv
// Fabric-side bundle of the DySER port buffer.
//   fab_in_vld/fab_in_data/fab_in_rdy    : input-FIFO heads offered to the fabric
//   fab_out_vld/fab_out_data/fab_out_rdy : fabric results pushed into output FIFOs
// Port p occupies data bits [p*DATA_W +: DATA_W].
// modport master : the port buffer side
// modport slave  : the fabric side
interface dyser_port_buf_if #(
  parameter int unsigned NPORTS = 8,
  parameter int unsigned DATA_W = 64
);

  logic [NPORTS-1:0]        fab_in_vld;
  logic [NPORTS*DATA_W-1:0] fab_in_data;
  logic [NPORTS-1:0]        fab_in_rdy;

  logic [NPORTS-1:0]        fab_out_vld;
  logic [NPORTS*DATA_W-1:0] fab_out_data;
  logic [NPORTS-1:0]        fab_out_rdy;

  modport master (
    output fab_in_vld,
    output fab_in_data,
    input  fab_in_rdy,
    input  fab_out_vld,
    input  fab_out_data,
    output fab_out_rdy
  );

  modport slave (
    input  fab_in_vld,
    input  fab_in_data,
    output fab_in_rdy,
    output fab_out_vld,
    output fab_out_data,
    input  fab_out_rdy
  );

endinterface

// File: rtl/dyser_port_buf.sv
// DySER port buffer: per-port input FIFOs (CPU -> fabric) and output FIFOs
// (fabric -> CPU) with two CPU send lanes and two CPU receive lanes.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   send_en0/1, send_port_r0/1, send_data_r0/1 : CPU send lanes
//   send_stall          : combinational, send request cannot complete
//   recv_en0/1, recv_port_r0/1 : CPU receive lanes
//   recv_data_r0/1      : combinational receive payloads
//   recv_stall          : combinational, receive request cannot complete
//   fab                 : fabric handshake bundle (master side)
//   flush               : synchronous clear of all FIFOs
//   in_ovf, out_unf     : sticky error flags, cleared only by reset
module dyser_port_buf #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NPORTS = 8,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PW    = $clog2(NPORTS)
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              send_en0,
  input  logic              send_en1,
  input  logic [PW-1:0]     send_port_r0,
  input  logic [PW-1:0]     send_port_r1,
  input  logic [DATA_W-1:0] send_data_r0,
  input  logic [DATA_W-1:0] send_data_r1,
  output logic              send_stall,

  input  logic              recv_en0,
  input  logic              recv_en1,
  input  logic [PW-1:0]     recv_port_r0,
  input  logic [PW-1:0]     recv_port_r1,
  output logic [DATA_W-1:0] recv_data_r0,
  output logic [DATA_W-1:0] recv_data_r1,
  output logic              recv_stall,

  dyser_port_buf_if.master  fab,

  input  logic              flush,
  output logic              in_ovf,
  output logic              out_unf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Input FIFOs (CPU send -> fabric)
  logic [DATA_W-1:0] in_mem [NPORTS][DEPTH];
  logic [AW-1:0]     in_rd  [NPORTS];
  logic [AW-1:0]     in_wr  [NPORTS];
  logic [CW-1:0]     in_cnt [NPORTS];

  // Output FIFOs (fabric -> CPU recv)
  logic [DATA_W-1:0] out_mem [NPORTS][DEPTH];
  logic [AW-1:0]     out_rd  [NPORTS];
  logic [AW-1:0]     out_wr  [NPORTS];
  logic [CW-1:0]     out_cnt [NPORTS];

  logic [NPORTS-1:0] in_vld;
  logic [NPORTS-1:0] in_push0;
  logic [NPORTS-1:0] in_push1;
  logic [NPORTS-1:0] in_pop;
  logic [NPORTS-1:0] out_rdy;
  logic [NPORTS-1:0] out_push;
  logic [NPORTS-1:0] out_pop0;
  logic [NPORTS-1:0] out_pop1;

  logic              send_same;
  logic              recv_same;
  logic [CW-1:0]     send_need;
  logic [CW-1:0]     recv_need;
  logic [CW-1:0]     send_free0;
  logic [CW-1:0]     send_free1;

  // Both lanes aimed at one port need two entries of space / data.
  assign send_same = send_en0 & send_en1 & (send_port_r0 == send_port_r1);
  assign recv_same = recv_en0 & recv_en1 & (recv_port_r0 == recv_port_r1);
  assign send_need = send_same ? CW'(2) : CW'(1);
  assign recv_need = recv_same ? CW'(2) : CW'(1);

  // Send stall: all enabled lanes complete together or not at all.
  always_comb begin
    send_free0 = CW'(DEPTH) - in_cnt[send_port_r0];
    send_free1 = CW'(DEPTH) - in_cnt[send_port_r1];
    send_stall = (send_en0 && (send_free0 < send_need)) ||
                 (send_en1 && (send_free1 < send_need));
  end

  // Receive stall: enabled lanes need enough valid words in their FIFO.
  always_comb begin
    recv_stall = (recv_en0 && (out_cnt[recv_port_r0] < recv_need)) ||
                 (recv_en1 && (out_cnt[recv_port_r1] < recv_need));
  end

  // Receive data: lane1 reads the second entry when sharing lane0's port.
  always_comb begin
    recv_data_r0 = '0;
    recv_data_r1 = '0;
    if (recv_en0 && (out_cnt[recv_port_r0] != '0)) begin
      recv_data_r0 = out_mem[recv_port_r0][out_rd[recv_port_r0]];
    end
    if (recv_same) begin
      if (out_cnt[recv_port_r1] >= CW'(2)) begin
        recv_data_r1 = out_mem[recv_port_r1][out_rd[recv_port_r1] + AW'(1)];
      end
    end else if (recv_en1 && (out_cnt[recv_port_r1] != '0)) begin
      recv_data_r1 = out_mem[recv_port_r1][out_rd[recv_port_r1]];
    end
  end

  // Per-port push/pop strobes and FIFO status.
  always_comb begin
    for (int p = 0; p < int'(NPORTS); p++) begin
      in_vld[p]   = (in_cnt[p] != '0);
      in_push0[p] = send_en0 & ~send_stall & (send_port_r0 == PW'(p));
      in_push1[p] = send_en1 & ~send_stall & (send_port_r1 == PW'(p));
      in_pop[p]   = in_vld[p] & fab.fab_in_rdy[p];
      out_rdy[p]  = (out_cnt[p] < CW'(DEPTH));
      out_push[p] = fab.fab_out_vld[p] & out_rdy[p];
      out_pop0[p] = recv_en0 & ~recv_stall & (recv_port_r0 == PW'(p));
      out_pop1[p] = recv_en1 & ~recv_stall & (recv_port_r1 == PW'(p));
    end
  end

  // Fabric-facing outputs; empty heads read as zero.
  always_comb begin
    fab.fab_in_vld  = in_vld;
    fab.fab_out_rdy = out_rdy;
    fab.fab_in_data = '0;
    for (int p = 0; p < int'(NPORTS); p++) begin
      if (in_vld[p]) begin
        fab.fab_in_data[p*DATA_W +: DATA_W] = in_mem[p][in_rd[p]];
      end
    end
  end

  // Input FIFO pointers and counts; flush beats every push and pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < int'(NPORTS); p++) begin
        in_rd[p]  <= '0;
        in_wr[p]  <= '0;
        in_cnt[p] <= '0;
      end
    end else if (flush) begin
      for (int p = 0; p < int'(NPORTS); p++) begin
        in_rd[p]  <= '0;
        in_wr[p]  <= '0;
        in_cnt[p] <= '0;
      end
    end else begin
      for (int p = 0; p < int'(NPORTS); p++) begin
        in_wr[p]  <= in_wr[p] + AW'(in_push0[p]) + AW'(in_push1[p]);
        in_rd[p]  <= in_rd[p] + AW'(in_pop[p]);
        in_cnt[p] <= in_cnt[p] + CW'(in_push0[p]) + CW'(in_push1[p])
                   - CW'(in_pop[p]);
      end
    end
  end

  // Output FIFO pointers and counts; flush beats every push and pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < int'(NPORTS); p++) begin
        out_rd[p]  <= '0;
        out_wr[p]  <= '0;
        out_cnt[p] <= '0;
      end
    end else if (flush) begin
      for (int p = 0; p < int'(NPORTS); p++) begin
        out_rd[p]  <= '0;
        out_wr[p]  <= '0;
        out_cnt[p] <= '0;
      end
    end else begin
      for (int p = 0; p < int'(NPORTS); p++) begin
        out_wr[p]  <= out_wr[p] + AW'(out_push[p]);
        out_rd[p]  <= out_rd[p] + AW'(out_pop0[p]) + AW'(out_pop1[p]);
        out_cnt[p] <= out_cnt[p] + CW'(out_push[p])
                    - CW'(out_pop0[p]) - CW'(out_pop1[p]);
      end
    end
  end

  // FIFO storage, not reset; lane0 lands before lane1 on a shared port.
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int p = 0; p < int'(NPORTS); p++) begin
        if (in_push0[p]) begin
          in_mem[p][in_wr[p]] <= send_data_r0;
        end
        if (in_push1[p]) begin
          in_mem[p][in_wr[p] + AW'(in_push0[p])] <= send_data_r1;
        end
        if (out_push[p]) begin
          out_mem[p][out_wr[p]] <= fab.fab_out_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Sticky error flags: fabric ready on empty input FIFO, fabric valid into full output FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ovf  <= 1'b0;
      out_unf <= 1'b0;
    end else begin
      in_ovf  <= in_ovf  | (|(fab.fab_in_rdy & ~in_vld));
      out_unf <= out_unf | (|(fab.fab_out_vld & ~out_rdy));
    end
  end

endmodule
